// File: rtl/gray_converter_round_robin_arbiter.sv
// Four requesters share one registered Binary-to-Gray converter.
// Arbitration is round-robin; each grant is followed by a one-cycle ack.
module gray_converter_round_robin_arbiter #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [3:0]                Req,
  input  logic [4*DATA_WIDTH-1:0]   Binary_Code_In,
  output logic [3:0]                Grant,
  output logic [3:0]                Ack,
  output logic [DATA_WIDTH-1:0]     Gray_Code_Out,
  output logic                      Gray_Valid,
  output logic                      Busy
);

  typedef enum logic {StIdle, StConvert} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] operand_q, operand_d;
  logic [DATA_WIDTH-1:0] gray_q, gray_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            winner_q, winner_d;
  logic [3:0]            grant_q, grant_d;
  logic [3:0]            ack_q, ack_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  logic                  found;
  logic [1:0]            pick;

  // Search starts at the priority pointer and wraps modulo 4.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && Req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    gray_d    = gray_q;
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    grant_d   = 4'b0000;
    ack_d     = 4'b0000;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          operand_d = Binary_Code_In[pick*DATA_WIDTH +: DATA_WIDTH];
          winner_d  = pick;
          grant_d   = 4'b0001 << pick;
          busy_d    = 1'b1;
          state_d   = StConvert;
        end
      end
      StConvert: begin
        // Req is ignored here; the operand was latched at grant time.
        gray_d  = operand_q ^ (operand_q >> 1);
        ack_d   = 4'b0001 << winner_q;
        valid_d = 1'b1;
        ptr_d   = winner_q + 2'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      operand_q <= '0;
      gray_q    <= '0;
      ptr_q     <= 2'd0;
      winner_q  <= 2'd0;
      grant_q   <= 4'b0000;
      ack_q     <= 4'b0000;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      gray_q    <= gray_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign Grant         = grant_q;
  assign Ack           = ack_q;
  assign Gray_Code_Out = gray_q;
  assign Gray_Valid    = valid_q;
  assign Busy          = busy_q;

endmodule

// File: tb/tb_gray_converter_round_robin_arbiter.sv
// Directed bench for the round-robin Gray converter arbiter.
module tb_gray_converter_round_robin_arbiter;

  logic        Clock;
  logic        Reset;
  logic [3:0]  Req;
  logic [15:0] Binary_Code_In;
  logic [3:0]  Grant;
  logic [3:0]  Ack;
  logic [3:0]  Gray_Code_Out;
  logic        Gray_Valid;
  logic        Busy;

  int n_cmp = 0;
  int n_err = 0;

  gray_converter_round_robin_arbiter #(.DATA_WIDTH(4)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Req            (Req),
    .Binary_Code_In (Binary_Code_In),
    .Grant          (Grant),
    .Ack            (Ack),
    .Gray_Code_Out  (Gray_Code_Out),
    .Gray_Valid     (Gray_Valid),
    .Busy           (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [3:0] v);
    Binary_Code_In[idx*4 +: 4] = v;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Req = 4'b0000;
    Binary_Code_In = 16'h0000;
    tick();
    tick();
    n_cmp++;
    if (Grant !== 4'b0000 || Ack !== 4'b0000 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got grant=%b ack=%b busy=%b want 0000 0000 0", Grant, Ack, Busy);
    end
    n_cmp++;
    if (Gray_Code_Out !== 4'b0000 || Gray_Valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_data: got out=%b valid=%b want 0000 0", Gray_Code_Out, Gray_Valid);
    end
    Reset = 1'b0;
  endtask

  task automatic test_single();
    set_op(2, 4'b1011);
    Req = 4'b0100;
    tick();
    n_cmp++;
    if (Grant !== 4'b0100 || Busy !== 1'b1 || Ack !== 4'b0000) begin
      n_err++;
      $display("FAIL single_grant: got grant=%b busy=%b ack=%b want 0100 1 0000", Grant, Busy, Ack);
    end
    tick();
    n_cmp++;
    if (Ack !== 4'b0100 || Gray_Valid !== 1'b1 || Gray_Code_Out !== 4'b1110) begin
      n_err++;
      $display("FAIL single_ack: got ack=%b valid=%b out=%b want 0100 1 1110",
               Ack, Gray_Valid, Gray_Code_Out);
    end
    n_cmp++;
    if (Grant !== 4'b0000 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_release: got grant=%b busy=%b want 0000 0", Grant, Busy);
    end
    Req = 4'b0000;
    tick();
    n_cmp++;
    if (Ack !== 4'b0000 || Gray_Valid !== 1'b0 || Gray_Code_Out !== 4'b1110) begin
      n_err++;
      $display("FAIL single_hold: got ack=%b valid=%b out=%b want 0000 0 1110",
               Ack, Gray_Valid, Gray_Code_Out);
    end
  endtask

  // Pointer is 3 after the single test: 1001 picks 3 first, then wraps to 0.
  task automatic test_pointer_wrap();
    logic [3:0] exp_g [2];
    logic [3:0] exp_o [2];
    exp_g[0] = 4'b1000; exp_o[0] = 4'b0101;
    exp_g[1] = 4'b0001; exp_o[1] = 4'b1000;
    set_op(0, 4'b1111);
    set_op(3, 4'b0110);
    for (int t = 0; t < 2; t++) begin
      Req = 4'b1001;
      tick();
      n_cmp++;
      if (Grant !== exp_g[t]) begin
        n_err++;
        $display("FAIL wrap_grant[%0d]: got %b want %b", t, Grant, exp_g[t]);
      end
      tick();
      n_cmp++;
      if (Ack !== exp_g[t] || Gray_Code_Out !== exp_o[t]) begin
        n_err++;
        $display("FAIL wrap_ack[%0d]: got ack=%b out=%b want %b %b",
                 t, Ack, Gray_Code_Out, exp_g[t], exp_o[t]);
      end
      Req = 4'b0000;
      tick();
    end
  endtask

  task automatic test_all_four();
    logic [3:0] exp_o [5];
    exp_o[0] = 4'b1000; exp_o[1] = 4'b0101; exp_o[2] = 4'b1100;
    exp_o[3] = 4'b0000; exp_o[4] = 4'b1000;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    set_op(0, 4'b1111);
    set_op(1, 4'b0110);
    set_op(2, 4'b1000);
    set_op(3, 4'b0000);
    Req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_cmp++;
      if (Grant !== (4'b0001 << (t % 4)) || Ack !== 4'b0000) begin
        n_err++;
        $display("FAIL all_grant[%0d]: got grant=%b ack=%b want %b 0000",
                 t, Grant, Ack, 4'b0001 << (t % 4));
      end
      tick();
      n_cmp++;
      if (Ack !== (4'b0001 << (t % 4)) || Gray_Code_Out !== exp_o[t] || Gray_Valid !== 1'b1) begin
        n_err++;
        $display("FAIL all_ack[%0d]: got ack=%b out=%b valid=%b want %b %b 1",
                 t, Ack, Gray_Code_Out, Gray_Valid, 4'b0001 << (t % 4), exp_o[t]);
      end
    end
    Req = 4'b0000;
    tick();
    n_cmp++;
    if (Busy !== 1'b0 || Grant !== 4'b0000 || Ack !== 4'b0000) begin
      n_err++;
      $display("FAIL all_idle: got busy=%b grant=%b ack=%b want 0 0000 0000", Busy, Grant, Ack);
    end
  endtask

  // Pointer is 1 here; requester 1 holds Req through its ack.
  task automatic test_back_to_back();
    set_op(1, 4'b0101);
    set_op(2, 4'b1011);
    Req = 4'b0110;
    tick();
    n_cmp++;
    if (Grant !== 4'b0010) begin
      n_err++;
      $display("FAIL b2b_grant1: got %b want 0010", Grant);
    end
    tick();
    n_cmp++;
    if (Ack !== 4'b0010 || Gray_Code_Out !== 4'b0111) begin
      n_err++;
      $display("FAIL b2b_ack1: got ack=%b out=%b want 0010 0111", Ack, Gray_Code_Out);
    end
    tick();
    n_cmp++;
    if (Grant !== 4'b0100 || Ack !== 4'b0000) begin
      n_err++;
      $display("FAIL b2b_grant2: got grant=%b ack=%b want 0100 0000", Grant, Ack);
    end
    tick();
    n_cmp++;
    if (Ack !== 4'b0100 || Gray_Code_Out !== 4'b1110) begin
      n_err++;
      $display("FAIL b2b_ack2: got ack=%b out=%b want 0100 1110", Ack, Gray_Code_Out);
    end
    Req = 4'b0010;
    tick();
    n_cmp++;
    if (Grant !== 4'b0010) begin
      n_err++;
      $display("FAIL b2b_grant3: got %b want 0010", Grant);
    end
    tick();
    n_cmp++;
    if (Ack !== 4'b0010 || Gray_Code_Out !== 4'b0111) begin
      n_err++;
      $display("FAIL b2b_ack3: got ack=%b out=%b want 0010 0111", Ack, Gray_Code_Out);
    end
    Req = 4'b0000;
    tick();
  endtask

  task automatic test_operand_change();
    set_op(1, 4'b0011);
    Req = 4'b0010;
    tick();
    n_cmp++;
    if (Grant !== 4'b0010 || Busy !== 1'b1) begin
      n_err++;
      $display("FAIL opchg_grant: got grant=%b busy=%b want 0010 1", Grant, Busy);
    end
    set_op(1, 4'b1111);
    Req = 4'b1111;
    tick();
    n_cmp++;
    if (Ack !== 4'b0010 || Gray_Code_Out !== 4'b0010) begin
      n_err++;
      $display("FAIL opchg_ack: got ack=%b out=%b want 0010 0010", Ack, Gray_Code_Out);
    end
    Req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_convert();
    set_op(2, 4'b0110);
    set_op(3, 4'b1010);
    Req = 4'b0100;
    tick();
    n_cmp++;
    if (Grant !== 4'b0100 || Gray_Code_Out !== 4'b0010) begin
      n_err++;
      $display("FAIL midrst_pre: got grant=%b out=%b want 0100 0010", Grant, Gray_Code_Out);
    end
    #3;
    Reset = 1'b1;
    #1;
    n_cmp++;
    if (Grant !== 4'b0000 || Busy !== 1'b0 || Gray_Code_Out !== 4'b0000) begin
      n_err++;
      $display("FAIL midrst_async: got grant=%b busy=%b out=%b want 0000 0 0000",
               Grant, Busy, Gray_Code_Out);
    end
    Req = 4'b0000;
    tick();
    n_cmp++;
    if (Ack !== 4'b0000 || Gray_Valid !== 1'b0 || Gray_Code_Out !== 4'b0000) begin
      n_err++;
      $display("FAIL midrst_noack: got ack=%b valid=%b out=%b want 0000 0 0000",
               Ack, Gray_Valid, Gray_Code_Out);
    end
    Reset = 1'b0;
    Req = 4'b1000;
    tick();
    n_cmp++;
    if (Grant !== 4'b1000) begin
      n_err++;
      $display("FAIL midrst_grant: got %b want 1000", Grant);
    end
    Req = 4'b0000;
    tick();
    n_cmp++;
    if (Ack !== 4'b1000 || Gray_Code_Out !== 4'b1111) begin
      n_err++;
      $display("FAIL midrst_ack: got ack=%b out=%b want 1000 1111", Ack, Gray_Code_Out);
    end
    // Pointer now 0 after the grant to 3: 0110 must pick requester 1.
    Req = 4'b0110;
    tick();
    n_cmp++;
    if (Grant !== 4'b0010) begin
      n_err++;
      $display("FAIL midrst_ptr: got %b want 0010", Grant);
    end
    Req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_pointer_wrap();
    test_all_four();
    test_back_to_back();
    test_operand_change();
    test_reset_mid_convert();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_converter_round_robin_arbiter.md
# gray_converter_round_robin_arbiter

Shares a single Binary-to-Gray conversion datapath among four independent requesters using round-robin arbitration and a registered request/acknowledge handshake. Each requester presents a binary operand. The block grants one requester at a time, converts that requester's operand, and returns a registered Gray result with a one-cycle acknowledge to the winner. It sits between the requester-side control logic and the shared Gray output bus.

## Interface
- DATA_WIDTH, 4, operand and result width in bits (≥2); the requester count is fixed at 4
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Req  input  4  request per requester; bit i belongs to requester i
- Binary_Code_In  input  4*DATA_WIDTH  packed operands; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- Grant  output  4  one-hot; high during CONVERT state for the winning requester
- Ack  output  4  one-hot, one-cycle pulse to the winner when the result is valid
- Gray_Code_Out  output  DATA_WIDTH  registered Gray result; holds the last result
- Gray_Valid  output  1  one-cycle pulse, coincident with Ack
- Busy  output  1  high while in CONVERT state

## Operation
- States are IDLE and CONVERT. The state register, Operand_Reg (DATA_WIDTH bits) and Priority_Ptr (2 bits) are internal.
- IDLE, when some Req bit is high at a rising edge:
  - Select the first set Req bit, searching Priority_Ptr, Priority_Ptr+1, … modulo 4 (3 wraps to 0).
  - Latch that requester's operand into Operand_Reg.
  - Set Grant to the winner's one-hot code.
  - Set Busy = 1.
  - Move to CONVERT.
- IDLE, no Req bit high: stay in IDLE. Grant = 0, Busy = 0.
- CONVERT, at the next rising edge, unconditionally:
  - Gray_Code_Out <= Operand_Reg ^ (Operand_Reg >> 1). The MSB passes through; bit k = b[k+1] ^ b[k].
  - Ack[winner] = 1 and Gray_Valid = 1, both for exactly one cycle.
  - Priority_Ptr <= winner + 1 mod 4.
  - Grant = 0, Busy = 0.
  - Return to IDLE.
- Req is not sampled in CONVERT. Changes to Req or Binary_Code_In during CONVERT do not affect the transaction in flight, because the operand is already latched.
- Requester rule: Req stays high until Ack is seen. A Req still high at the edge that ends the Ack cycle counts as a new request and is arbitrated normally against the rotated pointer.
- Ack, Gray_Valid and Grant are never asserted for more than one requester.
- Gray_Code_Out changes only on CONVERT completion and never glitches between results.

## Timing
- Reset (asynchronous, takes effect immediately) drives:
  - state = IDLE, Priority_Ptr = 0, Operand_Reg = 0
  - Grant = 0, Ack = 0, Gray_Code_Out = 0, Gray_Valid = 0, Busy = 0
- Reset asserted during CONVERT aborts the transaction: no Ack and no output update, and the pointer returns to 0.
- First arbitration after Reset deasserts happens at the first rising edge with Reset low.
- Latency:
  - Req sampled at edge k → Grant/Busy high during cycle k..k+1.
  - Ack, Gray_Valid and the new Gray_Code_Out are valid during cycle k+1..k+2.
  - Ack falls at edge k+2.
- Throughput is one conversion per 2 cycles. A new arbitration can occur at edge k+2, the same edge at which Ack clears.
- Fairness: with all four requesters held high continuously, grants follow 0,1,2,3,0,… A requester waits at most 3 other conversions (6 cycles) after its Req is sampled in IDLE.
- Outputs are registered with no combinational path from Req or Binary_Code_In to any output.

## Test plan
- Reset then single request: Req=4'b0100, operand2=4'b1011 → Grant=4'b0100 for 1 cycle, then Ack=4'b0100, Gray_Valid=1, Gray_Code_Out=4'b1110; Priority_Ptr becomes 3.
- All four Req high from reset, operands 0:4'b1111, 1:4'b0110, 2:4'b1000, 3:4'b0000 → Acks in order 0,1,2,3,0 at 2-cycle spacing; outputs 1000, 0101, 1100, 0000, 1000.
- Pointer wrap: after a grant to 3, Req=4'b1001 → requester 0 wins, not 3.
- Requester 1 holds Req through its Ack while Req=4'b0110 → next grant goes to 2, then back to 1.
- Operand change during CONVERT: operand1 switches from 4'b0011 to 4'b1111 after Grant → Gray_Code_Out=4'b0010.
- Reset pulse mid-CONVERT → all outputs go to 0 immediately, no Ack issued; a subsequent Req=4'b1000 is granted requester 3 with the pointer starting from 0.
